// File: rtl/vmem_pkg.sv
// ---------------------------------------------------------------------------
// vmem_pkg
// Shared definitions for the vector memory controller:
//   op_e       - request opcode encodings
//   state_e    - controller FSM states
//   lane_idx_w - width of a lane index for a given lane count (min 1 bit)
// ---------------------------------------------------------------------------
package vmem_pkg;

   typedef enum logic [1:0] {
      OP_LOAD    = 2'b00,
      OP_STORE   = 2'b01,
      OP_RSVD    = 2'b10,
      OP_SGATHER = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_GATHER = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   function automatic int lane_idx_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   localparam int LANES_DEFAULT = 16;
   localparam int LANE_IDX_W    = lane_idx_w(LANES_DEFAULT);

endpackage

// File: rtl/vmem_if.sv
// ---------------------------------------------------------------------------
// vmem_if
// Request/response bus between the vector load/store unit (master) and the
// vector memory controller (slave).
//   req_valid/req_ready  request handshake
//   req_op               00 load, 01 store, 10 reserved, 11 strided load
//   req_addr/req_stride  word address / element stride (ADDR_W bits)
//   req_mask             per-lane enable
//   req_wdata            store data, lane i = bits [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata/rsp_err    load data / illegal-request flag
//   busy                 controller not idle
// ---------------------------------------------------------------------------
interface vmem_if #(
   parameter int DATA_W = 32,
   parameter int LANES  = 16,
   parameter int ADDR_W = 9
);
   logic                    req_valid;
   logic                    req_ready;
   logic [1:0]              req_op;
   logic [ADDR_W-1:0]       req_addr;
   logic [ADDR_W-1:0]       req_stride;
   logic [LANES-1:0]        req_mask;
   logic [LANES*DATA_W-1:0] req_wdata;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [LANES*DATA_W-1:0] rsp_rdata;
   logic                    rsp_err;
   logic                    busy;

   modport master (
      output req_valid, req_op, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_stride, req_mask, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/vmem_agen.sv
// ---------------------------------------------------------------------------
// vmem_agen
// Gather address generator. Instead of multiplying lane index by stride it
// keeps a running element address: loaded with the request base on start,
// advanced by the captured stride once per gather lane. Arithmetic is
// ADDR_W bits wide, so wrap-around modulo DEPTH is implicit.
// Ports:
//   clk        clock
//   start      load base/stride (request accepted)
//   base       starting word address
//   stride     element stride
//   advance    step to the next lane's address
//   elem_addr  address of the current gather lane
// ---------------------------------------------------------------------------
module vmem_agen #(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] stride,
   input  logic              advance,
   output logic [ADDR_W-1:0] elem_addr
);

   logic [ADDR_W-1:0] acc_q;
   logic [ADDR_W-1:0] stride_q;

   always_ff @(posedge clk) begin
      if (start) begin
         acc_q    <= base;
         stride_q <= stride;
      end else if (advance) begin
         acc_q <= acc_q + stride_q;
      end
   end

   assign elem_addr = acc_q;

endmodule

// File: rtl/vector_mem_ctrl.sv
// ---------------------------------------------------------------------------
// vector_mem_ctrl
// Single-port word memory (2**ADDR_W words of DATA_W bits) accessed as
// LANES-wide vectors, with valid/ready request and response handshakes and
// per-lane masks. One transaction in flight.
//   op 00 load  : aligned vector read, masked lanes return 0
//   op 01 store : aligned vector write of enabled lanes, single-cycle commit
//   op 10       : illegal, answered with rsp_err
//   op 11       : strided gather, one lane per cycle (VMEM_STRIDE_EN),
//                 otherwise illegal like op 10
// Optional feature macro: VMEM_STRIDE_EN (builds gather state + vmem_agen).
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (control state and response only;
//        memory contents are kept)
//   bus  vmem_if slave modport (request/response handshake, busy)
// INIT_FILE names the memory image the platform loader preloads; the array
// itself has no reset and no built-in initialisation.
// ---------------------------------------------------------------------------
module vector_mem_ctrl
   import vmem_pkg::*;
#(
   parameter int    DATA_W    = 32,
   parameter int    LANES     = 16,
   parameter int    ADDR_W    = 9,
   parameter string INIT_FILE = "hex_file.txt"
) (
   input logic   clk,
   input logic   rst,
   vmem_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int LIW   = lane_idx_w(LANES);
   // Unit-stride accesses clear the lane-index bits of the address.
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LANES-1);

   logic [DATA_W-1:0]       mem [DEPTH];

   state_e                  state;
   state_e                  state_nx;
   op_e                     op_in;
   op_e                     op_q;
   logic [ADDR_W-1:0]       base_q;
   logic [LANES-1:0]        mask_q;
   logic [LANES*DATA_W-1:0] wdata_q;
   logic [LANES*DATA_W-1:0] rdata_q;
   logic [LANES*DATA_W-1:0] load_vec;
   logic                    err_q;
   logic                    accept;
   logic                    op_is_err;

   assign op_in  = op_e'(bus.req_op);
   assign accept = bus.req_valid && (state == S_IDLE);

`ifdef VMEM_STRIDE_EN
   assign op_is_err = (op_in == OP_RSVD);
`else
   // Without the gather datapath op 11 is answered like the reserved op.
   assign op_is_err = (op_in == OP_RSVD) || (op_in == OP_SGATHER);
`endif

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

`ifdef VMEM_STRIDE_EN
   logic [LIW-1:0]    cnt_q;
   logic [ADDR_W-1:0] elem_addr;
   logic              gather_step;

   assign gather_step = (state == S_GATHER);

   vmem_agen #(
      .ADDR_W (ADDR_W)
   ) u_agen (
      .clk       (clk),
      .start     (accept),
      .base      (bus.req_addr),
      .stride    (bus.req_stride),
      .advance   (gather_step),
      .elem_addr (elem_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (gather_step) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   logic unused_stride;
   assign unused_stride = ^bus.req_stride;
`endif

   // ---- FSM: next-state logic ----
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (op_is_err) begin
                  state_nx = S_RESP;
`ifdef VMEM_STRIDE_EN
               end else if (op_in == OP_SGATHER) begin
                  state_nx = S_GATHER;
`endif
               end else begin
                  state_nx = S_ACCESS;
               end
            end
         end
         S_ACCESS: state_nx = S_RESP;
`ifdef VMEM_STRIDE_EN
         S_GATHER: begin
            if (cnt_q == LIW'(LANES-1)) begin
               state_nx = S_RESP;
            end
         end
`endif
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      bus.req_ready = (state == S_IDLE);
      bus.rsp_valid = (state == S_RESP);
      bus.busy      = (state != S_IDLE);
   end

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   // ---- request capture (data, not reset) ----
   always_ff @(posedge clk) begin
      if (accept) begin
         op_q    <= op_in;
         base_q  <= bus.req_addr & ALIGN_MASK;
         mask_q  <= bus.req_mask;
         wdata_q <= bus.req_wdata;
      end
   end

   // Aligned vector read; base is aligned so base+i never crosses a vector.
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < LANES; i++) begin
         if (mask_q[i]) begin
            load_vec[i*DATA_W +: DATA_W] = mem[base_q + ADDR_W'(i)];
         end
      end
   end

   // ---- access stage: memory write ----
   // Gated by rst so a reset on the commit edge leaves memory untouched.
   always_ff @(posedge clk) begin
      if (!rst && (state == S_ACCESS) && (op_q == OP_STORE)) begin
         for (int i = 0; i < LANES; i++) begin
            if (mask_q[i]) begin
               mem[base_q + ADDR_W'(i)] <= wdata_q[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // ---- response register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            rdata_q <= '0;
            err_q   <= op_is_err;
         end else if (state == S_ACCESS) begin
            rdata_q <= (op_q == OP_LOAD) ? load_vec : '0;
`ifdef VMEM_STRIDE_EN
         end else if (state == S_GATHER) begin
            rdata_q[int'(cnt_q)*DATA_W +: DATA_W] <= mask_q[cnt_q] ? mem[elem_addr] : '0;
`endif
         end else if ((state == S_RESP) && bus.rsp_ready) begin
            err_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vector_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vector_mem_ctrl
// Self-checking bench: a behavioural model (flat word array + per-op rules)
// predicts each response and its latency; a negedge process compares all
// outputs every cycle, and a few literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_vector_mem_ctrl;

   localparam int DATA_W = 32;
   localparam int LANES  = 16;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 512;
   localparam int VW     = LANES*DATA_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vmem_if #(.DATA_W(DATA_W), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

   vector_mem_ctrl #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;

   logic [DATA_W-1:0] mm [DEPTH];

   bit            chk_en = 1'b0;
   logic          exp_ready, exp_busy, exp_valid, exp_err, rd_chk;
   logic [VW-1:0] exp_rdata;
   logic [VW-1:0] last_rsp;
   logic          last_err;

   task automatic cmp(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every output against the model's expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("req_ready", VW'(bus.req_ready), VW'(exp_ready));
         cmp("busy",      VW'(bus.busy),      VW'(exp_busy));
         cmp("rsp_valid", VW'(bus.rsp_valid), VW'(exp_valid));
         cmp("rsp_err",   VW'(bus.rsp_err),   VW'(exp_err));
         if (rd_chk) cmp("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
   end

   task automatic set_idle();
      exp_ready = 1'b1;
      exp_busy  = 1'b0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      rd_chk    = 1'b1;
      exp_rdata = last_rsp;
   endtask

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] v;
      for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = $urandom;
      return v;
   endfunction

   // Behavioural model: response data, error flag and edges-after-accept
   // (accept edge counted as 1) for one request; stores update mm.
   task automatic model(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                        input logic [ADDR_W-1:0] stride, input logic [LANES-1:0] mask,
                        input logic [VW-1:0] wd, output logic [VW-1:0] rd,
                        output logic err, output int lat);
      int base;
      base = int'(addr) - (int'(addr) % LANES);
      rd   = '0;
      err  = 1'b0;
      lat  = 2;
      case (op)
         2'b00: for (int i = 0; i < LANES; i++)
                   if (mask[i]) rd[i*DATA_W +: DATA_W] = mm[base+i];
         2'b01: for (int i = 0; i < LANES; i++)
                   if (mask[i]) mm[base+i] = wd[i*DATA_W +: DATA_W];
         2'b10: begin err = 1'b1; lat = 1; end
         default: begin
`ifdef VMEM_STRIDE_EN
            lat = LANES + 1;
            for (int i = 0; i < LANES; i++)
               if (mask[i]) rd[i*DATA_W +: DATA_W] = mm[(int'(addr) + i*int'(stride)) % DEPTH];
`else
            err = 1'b1;
            lat = 1;
`endif
         end
      endcase
   endtask

   // One transaction: hold = cycles of rsp_ready=0 after rsp_valid rises;
   // rst_k >= 0 asserts reset after that many post-accept edges instead.
   task automatic txn(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                      input logic [ADDR_W-1:0] stride, input logic [LANES-1:0] mask,
                      input logic [VW-1:0] wd, input int hold, input int rst_k);
      logic [VW-1:0] e_rd;
      logic          e_err;
      int            lat;
      model(op, addr, stride, mask, wd, e_rd, e_err, lat);
      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.req_addr   = addr;
      bus.req_stride = stride;
      bus.req_mask   = mask;
      bus.req_wdata  = wd;
      bus.rsp_ready  = 1'b0;
      for (int k = 0; k < lat + hold; k++) begin
         @(posedge clk); #1;
         bus.req_valid = 1'b0;
         exp_ready = 1'b0;
         exp_busy  = 1'b1;
         exp_err   = e_err;
         exp_valid = (k >= lat - 1);
         rd_chk    = exp_valid;
         exp_rdata = e_rd;
         if (k == lat - 1) last_err = bus.rsp_err;
         if (k == rst_k) begin
            bus.rsp_ready = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            last_rsp = '0;
            set_idle();
            return;
         end
         if (k < lat - 1) begin
            bus.rsp_ready = 1'($urandom % 2);
         end else begin
            // Stray requests while a response is pending must be ignored.
            bus.rsp_ready  = 1'b0;
            bus.req_valid  = 1'($urandom % 2);
            bus.req_op     = 2'($urandom);
            bus.req_addr   = ADDR_W'($urandom);
            bus.req_mask   = LANES'($urandom);
            bus.req_wdata  = rand_vec();
         end
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      last_rsp = e_rd;
      set_idle();
   endtask

   initial begin
      logic [VW-1:0] wd;
      logic [1:0]    op;
      logic [LANES-1:0] mask;
      int            r;

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = '0;
      bus.req_addr   = '0;
      bus.req_stride = '0;
      bus.req_mask   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      last_rsp       = '0;
      last_err       = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cmp("reset_req_ready", VW'(bus.req_ready), VW'(1'b1));
      cmp("reset_rsp_valid", VW'(bus.rsp_valid), VW'(1'b0));
      cmp("reset_rdata",     bus.rsp_rdata,      '0);

      // Preload mem[k] = k through full-mask stores.
      for (int b = 0; b < DEPTH / LANES; b++) begin
         for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = DATA_W'(b*LANES + i);
         txn(2'b01, ADDR_W'(b*LANES), '0, '1, wd, 0, -1);
      end

      // Aligned load: addr 0x25 -> base 0x20.
      txn(2'b00, 9'h025, '0, 16'hFFFF, '0, 0, -1);
      for (int i = 0; i < LANES; i++)
         cmp("load_aligned_lane", VW'(bus.rsp_rdata[i*DATA_W +: DATA_W]), VW'(32'h20 + i));

      // Masked store then reload with 5 cycles of backpressure.
      for (int i = 0; i < LANES; i++) wd[i*DATA_W +: DATA_W] = 32'hA000 + i;
      txn(2'b01, 9'h040, '0, 16'h00F0, wd, 0, -1);
      txn(2'b00, 9'h040, '0, 16'hFFFF, '0, 5, -1);
      for (int i = 0; i < LANES; i++)
         cmp("masked_store_lane", VW'(bus.rsp_rdata[i*DATA_W +: DATA_W]),
             VW'((i >= 4 && i <= 7) ? 32'hA000 + i : 32'h40 + i));

      // Reserved op.
      txn(2'b10, 9'h011, '0, 16'hFFFF, '0, 2, -1);
      cmp("op10_err", VW'(last_err), VW'(1'b1));
      cmp("op10_rdata", bus.rsp_rdata, '0);

      // Mask all-zero load.
      txn(2'b00, 9'h080, '0, 16'h0000, '0, 0, -1);
      cmp("mask_zero_rdata", bus.rsp_rdata, '0);

`ifdef VMEM_STRIDE_EN
      // Strided gather wrapping past the top of memory.
      txn(2'b11, 9'h1F0, 9'd3, 16'hFFFF, '0, 1, -1);
      cmp("gather_lane0",  VW'(bus.rsp_rdata[0*DATA_W +: DATA_W]),  VW'(32'h1F0));
      cmp("gather_lane4",  VW'(bus.rsp_rdata[4*DATA_W +: DATA_W]),  VW'(32'h1FC));
      cmp("gather_lane15", VW'(bus.rsp_rdata[15*DATA_W +: DATA_W]), VW'(32'h01D));
      // Stride 0 broadcast.
      txn(2'b11, 9'h033, 9'd0, 16'hA5A5, '0, 0, -1);
      cmp("bcast_lane0", VW'(bus.rsp_rdata[0*DATA_W +: DATA_W]), VW'(32'h33));
      cmp("bcast_lane1", VW'(bus.rsp_rdata[1*DATA_W +: DATA_W]), VW'(32'h0));
      // Reset at gather lane 6, then a fresh load.
      txn(2'b11, 9'h1F0, 9'd3, 16'hFFFF, '0, 0, 6);
      cmp("rst_gather_ready", VW'(bus.req_ready), VW'(1'b1));
      txn(2'b00, 9'h047, '0, 16'hFFFF, '0, 0, -1);
      cmp("post_rst_lane5", VW'(bus.rsp_rdata[5*DATA_W +: DATA_W]), VW'(32'hA005));
`else
      // Op 11 without the gather datapath.
      txn(2'b11, 9'h1F0, 9'd3, 16'hFFFF, '0, 1, -1);
      cmp("op11_off_err", VW'(last_err), VW'(1'b1));
      cmp("op11_off_rdata", bus.rsp_rdata, '0);
`endif

      // Reset while a response is pending.
      txn(2'b00, 9'h100, '0, 16'hFFFF, '0, 4, 2);
      cmp("rst_resp_rdata", bus.rsp_rdata, '0);
      txn(2'b00, 9'h100, '0, 16'hFFFF, '0, 0, -1);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         r = int'($urandom % 8);
         op = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r == 5) ? 2'b10 : 2'b11;
         r = int'($urandom % 4);
         mask = (r == 0) ? '0 : (r == 1) ? '1 : LANES'($urandom);
         txn(op, ADDR_W'($urandom), ADDR_W'($urandom % 4 == 0 ? 0 : $urandom),
             mask, rand_vec(), int'($urandom % 4), -1);
      end

      repeat (2) @(posedge clk);
      #1 chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
